// File: rtl/fetch_sequencer_if.sv
// Bundle of the fetch sequencer's handshake and bus signals.
// Latency: none (wires only).
// Backpressure: out_ready from the decode side stalls the sequencer.
//
// master: the fetch sequencer (drives imem_addr and the output register).
// slave : the surrounding system (instruction memory, branch unit, decode).
//   start          - one-cycle pulse that starts or restarts fetching
//   imem_addr      - word address to instruction memory
//   imem_inst      - instruction word at imem_addr, same cycle
//   redirect_valid - taken branch/jump, overrides sequential fetch
//   redirect_pc    - target word address
//   out_valid      - output register holds a fetched instruction
//   out_ready      - decode accepts the output this cycle
//   out_inst       - fetched instruction word
//   out_pc         - address out_inst was fetched from
//   busy / halted  - status decodes of the sequencer state
interface fetch_sequencer_if;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        busy;
  logic        halted;

  modport master (
    input  start,
    input  imem_inst,
    input  redirect_valid,
    input  redirect_pc,
    input  out_ready,
    output imem_addr,
    output out_valid,
    output out_inst,
    output out_pc,
    output busy,
    output halted
  );

  modport slave (
    output start,
    output imem_inst,
    output redirect_valid,
    output redirect_pc,
    output out_ready,
    input  imem_addr,
    input  out_valid,
    input  out_inst,
    input  out_pc,
    input  busy,
    input  halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads a word-indexed memory, feeds decode.
// Latency: 1 cycle from imem_addr to out_inst/out_pc; one instruction per cycle when unstalled.
// Backpressure: a held output with out_ready low stalls the PC and imem_addr; accept+refill has no bubble.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - fetch_sequencer_if.master (memory, redirect, output register, status)
// Parameters:
//   DEPTH    - number of instruction words, power of 2; the PC wraps modulo DEPTH
//   START_PC - word address loaded on reset and on every start
//   HALT_OP  - opcode (inst[31:26]) that ends the program
module fetch_sequencer #(
  parameter int unsigned DEPTH    = 128,
  parameter logic [31:0] START_PC = 32'd0,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.master bus
);

  localparam int unsigned PCW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PCW-1:0] PC_START = START_PC[PCW-1:0];
  localparam logic [PCW-1:0] PC_ONE   = PCW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [PCW-1:0] pc;
  logic [PCW-1:0] pc_nxt;
  logic           out_valid;
  logic           out_valid_nxt;
  logic [31:0]    out_inst;
  logic [31:0]    out_inst_nxt;
  logic [PCW-1:0] out_pc;
  logic [PCW-1:0] out_pc_nxt;
  logic           busy;
  logic           halted;

  logic           accept;
  logic           fire;
  logic           is_halt;

  // Only the low PCW bits of the redirect target address memory; the rest
  // are folded here so they are visibly intentionally ignored.
  logic           unused_redirect_bits;
  assign unused_redirect_bits = ^bus.redirect_pc[31:PCW];

  assign accept  = out_valid && bus.out_ready;
  // The output register can take a new word when it is empty or being drained.
  assign fire    = !out_valid || bus.out_ready;
  assign is_halt = (bus.imem_inst[31:26] == HALT_OP);

  // Next-state and datapath decisions. Priority: start > redirect > fire/stall.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    out_valid_nxt = out_valid;
    out_inst_nxt  = out_inst;
    out_pc_nxt    = out_pc;

    if (bus.start) begin
      // Start or restart from any state; whatever is pending is dropped.
      state_nxt     = RUN;
      pc_nxt        = PC_START;
      out_valid_nxt = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            out_valid_nxt = 1'b0;
          end
        end

        RUN: begin
          if (bus.redirect_valid) begin
            // Flush the wrong-path word; fetch from the target next cycle.
            out_valid_nxt = 1'b0;
            pc_nxt        = bus.redirect_pc[PCW-1:0];
          end else if (fire) begin
            out_valid_nxt = 1'b1;
            out_inst_nxt  = bus.imem_inst;
            out_pc_nxt    = pc;
            if (is_halt) begin
              // The halt word is delivered like any other, but the PC stays
              // on it so imem_addr points at the halt address while halted.
              state_nxt = HALT;
            end else begin
              pc_nxt = pc + PC_ONE;
            end
          end
        end

        HALT: begin
          // Keep presenting the halt instruction until decode takes it.
          if (accept) begin
            out_valid_nxt = 1'b0;
          end
        end

        default: begin
          state_nxt     = IDLE;
          out_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= PC_START;
      out_valid <= 1'b0;
      out_inst  <= 32'd0;
      out_pc    <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      out_valid <= out_valid_nxt;
      out_inst  <= out_inst_nxt;
      out_pc    <= out_pc_nxt;
      // Decoded from the next state so the flags line up with the state register.
      busy      <= (state_nxt == RUN);
      halted    <= (state_nxt == HALT);
    end
  end

  assign bus.imem_addr = {{(32-PCW){1'b0}}, pc};
  assign bus.out_valid = out_valid;
  assign bus.out_inst  = out_inst;
  assign bus.out_pc    = {{(32-PCW){1'b0}}, out_pc};
  assign bus.busy      = busy;
  assign bus.halted    = halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .DEPTH   (DEPTH),
    .START_PC(32'd0),
    .HALT_OP (6'b111111)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];
  assign bus.imem_inst = mem[bus.imem_addr[6:0]];

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic        start;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic ev, input logic [31:0] epc, input logic [31:0] eaddr);
    vec_t v;
    v.start = s; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    else
      passed++;
  endtask

  // Compare the full visible state; out_pc/out_inst only matter while out_valid.
  task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                         input logic [31:0] einst, input logic [31:0] eaddr,
                         input logic ebusy, input logic ehalt);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(ev));
    chk({tag, " imem_addr"}, bus.imem_addr, eaddr);
    chk({tag, " busy"}, 32'(bus.busy), 32'(ebusy));
    chk({tag, " halted"}, 32'(bus.halted), 32'(ehalt));
    if (ev) begin
      chk({tag, " out_pc"}, bus.out_pc, epc);
      chk({tag, " out_inst"}, bus.out_inst, einst);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic rv, input logic [31:0] rpc, input logic rdy);
    bus.start          = s;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
  endtask

  // Reference model state for the random phase.
  bit          m_run, m_halt, m_ov;
  int          m_pc, m_opc;
  logic [31:0] m_oinst;

  initial begin
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'(k);

    // ---------------- reset values ----------------
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk_all("reset", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("reset out_pc", bus.out_pc, 32'd0);
    chk("reset out_inst", bus.out_inst, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_all("idle", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // ---------------- table-driven vectors (mem[k] = k) ----------------
    add(1'b1, 1'b0, 32'd0,   1'b1, 1'b0, 32'd0,   32'd0);   // start
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd0,   32'd1);
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd1,   32'd2);
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd2,   32'd3);
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd3,   32'd4);
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd4,   32'd5);
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd5,   32'd6);
    add(1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 32'd5,   32'd6);   // stall x3
    add(1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 32'd5,   32'd6);
    add(1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 32'd5,   32'd6);
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd6,   32'd7);   // release
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd7,   32'd8);
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd8,   32'd9);
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd9,   32'd10);
    add(1'b0, 1'b1, 32'd40,  1'b1, 1'b0, 32'd0,   32'd40);  // redirect at pc=10
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd40,  32'd41);
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd41,  32'd42);
    add(1'b0, 1'b1, 32'd200, 1'b1, 1'b0, 32'd0,   32'd72);  // 200 mod 128
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd72,  32'd73);
    add(1'b0, 1'b1, 32'd126, 1'b1, 1'b0, 32'd0,   32'd126); // toward wrap
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd126, 32'd127);
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd127, 32'd0);
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd0,   32'd1);
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd1,   32'd2);
    add(1'b1, 1'b1, 32'd50,  1'b1, 1'b0, 32'd0,   32'd0);   // start beats redirect
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd0,   32'd1);
    add(1'b0, 1'b1, 32'd20,  1'b0, 1'b0, 32'd0,   32'd20);  // redirect while stalled
    add(1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 32'd20,  32'd21);  // empty reg fills
    add(1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 32'd20,  32'd21);
    add(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd21,  32'd22);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].start, vq[i].rv, vq[i].rpc, vq[i].rdy);
      step();
      chk_all($sformatf("vec%0d", i), vq[i].ev, vq[i].epc, vq[i].epc, vq[i].eaddr, 1'b1, 1'b0);
    end

    // ---------------- halt sequence ----------------
    mem[3] = {6'b111111, 26'd0};
    drive(1'b1, 1'b0, 32'd0, 1'b1); step();
    chk_all("h_start", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b1); step();
    chk_all("h_f0", 1'b1, 32'd0, 32'd0, 32'd1, 1'b1, 1'b0);
    step();
    chk_all("h_f1", 1'b1, 32'd1, 32'd1, 32'd2, 1'b1, 1'b0);
    step();
    chk_all("h_f2", 1'b1, 32'd2, 32'd2, 32'd3, 1'b1, 1'b0);
    step();
    chk_all("h_cap", 1'b1, 32'd3, {6'b111111, 26'd0}, 32'd3, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 32'd9, 1'b0); step();   // redirect ignored, output held
    chk_all("h_hold", 1'b1, 32'd3, {6'b111111, 26'd0}, 32'd3, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 32'd0, 1'b1); step();
    chk_all("h_acc", 1'b0, 32'd0, 32'd0, 32'd3, 1'b0, 1'b1);
    step();
    chk_all("h_idle", 1'b0, 32'd0, 32'd0, 32'd3, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 32'd0, 1'b1); step();
    chk_all("h_restart", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b1); step();
    chk_all("h_resume", 1'b1, 32'd0, 32'd0, 32'd1, 1'b1, 1'b0);
    mem[3] = 32'd3;

    // ---------------- asynchronous reset mid-run ----------------
    step(); step(); step(); step();
    chk_all("pre_rst", 1'b1, 32'd4, 32'd4, 32'd5, 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("post_rst%0d", i), 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    end

    // ---------------- random stimulus vs reference model ----------------
    for (int k = 0; k < DEPTH; k++) begin
      mem[k] = $urandom;
      if ($urandom_range(0, 19) == 0) mem[k][31:26] = 6'b111111;
    end
    m_run = 0; m_halt = 0; m_ov = 0; m_pc = 0; m_opc = 0; m_oinst = 32'd0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic        s, rv, rdy;
      logic [31:0] rpc;
      s   = ($urandom_range(0, 39) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      rdy = ($urandom_range(0, 3) != 0);
      drive(s, rv, rpc, rdy);

      // Rules: start wins; in RUN a redirect flushes and jumps, otherwise the
      // output register loads whenever it is empty or being drained; a halt
      // opcode stops fetching with the PC left on it. Outside RUN only a drain happens.
      if (s) begin
        m_run = 1; m_halt = 0; m_ov = 0; m_pc = 0;
      end else if (m_run) begin
        if (rv) begin
          m_ov = 0;
          m_pc = int'(rpc % 32'(DEPTH));
        end else if (!m_ov || rdy) begin
          m_ov = 1;
          m_opc = m_pc;
          m_oinst = mem[m_pc];
          if (m_oinst[31:26] == 6'b111111) begin
            m_run = 0; m_halt = 1;
          end else begin
            m_pc = (m_pc + 1) % DEPTH;
          end
        end
      end else if (m_ov && rdy) begin
        m_ov = 0;
      end

      step();
      chk_all($sformatf("rnd%0d", cyc), m_ov, 32'(m_opc), m_oinst, 32'(m_pc), m_run, m_halt);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that owns the program counter and sequences the word-indexed instruction memory.
- Drives the memory address and samples the combinational instruction word, which is returned in the same cycle.
- Hands each fetched word to the decode stage through a one-entry valid/ready output register.
- Handles stall, branch/jump redirect, halt detection, start/restart and PC wrap-around.

Parameters:
- DEPTH, 128, number of instruction words; PC wraps modulo DEPTH; must be a power of 2.
- START_PC, 0, word address loaded on reset and on every start.
- HALT_OP, 6'b111111, opcode (inst[31:26]) that ends the program.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins or restarts fetching at START_PC.
- imem_addr  output  32  word address to instruction memory; equals pc; upper bits are 0.
- imem_inst  input  32  instruction word at imem_addr, valid in the same cycle.
- redirect_valid  input  1  branch/jump taken; overrides sequential fetch.
- redirect_pc  input  32  target word address; only the low log2(DEPTH) bits are used.
- out_valid  output  1  out_inst and out_pc hold a fetched instruction.
- out_ready  input  1  decode accepts the output when out_valid && out_ready.
- out_inst  output  32  registered instruction word.
- out_pc  output  32  word address that out_inst was fetched from.
- busy  output  1  high in RUN.
- halted  output  1  high in HALT.

Behaviour:
- Reset values (asynchronous): state=IDLE, pc=START_PC, out_valid=0, out_inst=0, out_pc=0, busy=0, halted=0.
- States are IDLE, RUN and HALT. busy and halted are registered decodes of the state.
- IDLE:
  - No fetch.
  - start -> pc=START_PC, out_valid=0, go to RUN.
- RUN, fetch condition: fire = !out_valid || out_ready.
- RUN, when fire:
  - out_inst <= imem_inst.
  - out_pc <= pc.
  - out_valid <= 1.
  - pc <= (pc+1) mod DEPTH.
  - Result: one instruction per cycle, with 1-cycle latency from address to output.
- RUN, when !fire (stall):
  - pc, out_inst, out_pc and out_valid hold.
  - imem_addr stays stable.
- RUN, halt:
  - A fire that captures opcode == HALT_OP loads that instruction normally.
  - Same edge: state -> HALT, and pc holds at the halt address (no increment).
- RUN, out_valid clearing: an accept (out_valid && out_ready) without a new fire in the same cycle clears out_valid. This does not occur in RUN, because accept implies fire.
- HALT:
  - No further fetch.
  - The pending output (the halt instruction) is still presented until accepted; on accept out_valid -> 0.
  - start -> pc=START_PC, out_valid=0, go to RUN.
- Redirect (RUN only, highest priority over fire/stall/halt):
  - out_valid <= 0 (flush).
  - pc <= redirect_pc mod DEPTH.
  - No capture that cycle.
  - Fetch resumes from the target on the next cycle.
  - redirect_valid is ignored in IDLE and HALT.
- start in RUN restarts: pc=START_PC, out_valid=0. start has priority over redirect.
- Wrap: pc = DEPTH-1 with fire -> pc = 0. The captured out_pc is DEPTH-1.
- Simultaneous accept and refill: the new word replaces the accepted one in the same edge, so out_valid stays 1 with no bubble.
- Reset asserted mid-operation: immediate return to the reset values; any pending output is discarded.

Test Plan:
- Reset, then start; memory words k hold 32'h0000_0000+k; out_ready=1 -> out_valid rises 1 cycle later; out_pc = 0, 1, 2, … on consecutive cycles; out_inst matches.
- out_ready held 0 for 3 cycles at out_pc=5 -> out_inst, out_pc=5 and imem_addr=6 stable for 3 cycles. Release -> out_pc=6 on the next cycle, no word lost or duplicated.
- redirect_valid with redirect_pc=40 while at pc=10 -> out_valid=0 for one cycle, then out_pc=40, 41, …. redirect_pc=200 with DEPTH=128 -> fetch at 72.
- Word 3 = {6'b111111, 26'b0} -> out_pc=3 presented, halted=1, busy=0, imem_addr stays 3. On accept out_valid=0. Then start -> fetch resumes at START_PC.
- Start at pc=126 via redirect with out_ready=1 -> out_pc sequence 126, 127, 0, 1.
- rst asserted asynchronously mid-RUN, between clock edges -> out_valid=0, pc=START_PC, state IDLE immediately. No fetch until start.
